// File: rtl/sample_serializer_if.sv
// Sample-in / nibble-out bus of the sample serializer.
// The slave modport is the serializer's view; the master is the sample
// source plus the downstream nibble sink.
interface sample_serializer_if;
  logic        Vld;
  logic [11:0] Din;
  logic        OutRdy;
  logic        OutVld;
  logic [3:0]  Dout;
  logic        Sof;
  logic [4:0]  Level;
  logic        Ovf;

  modport master (output Vld, Din, OutRdy,
                  input  OutVld, Dout, Sof, Level, Ovf);
  modport slave  (input  Vld, Din, OutRdy,
                  output OutVld, Dout, Sof, Level, Ovf);
endinterface

// File: rtl/sample_serializer.sv
// NCO sample serializer.
// A DEPTH x 12 circular FIFO buffers samples. A 4-state FSM pops one sample
// at a time into a holding register and presents it as three nibbles,
// MSB nibble first. All outputs come straight from registers.
module sample_serializer #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  sample_serializer_if.slave bus
);
  localparam int             AW   = $clog2(DEPTH);
  localparam logic [4:0]     FULL = 5'(DEPTH);
  localparam logic [AW-1:0]  ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, N2, N1, N0} state_t;

  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [4:0]    level_q, level_d;
  logic          ovf_q, ovf_d;
  state_t        state_q;
  logic [11:0]   hold_q;
  logic          outvld_q, sof_q;
  logic [3:0]    dout_q;
  logic          pop, wr;
  logic [11:0]   head;

  assign head = mem_q[rptr_q];

  // Pop/write decisions and next-state of pointers, occupancy and overflow.
  // A pop uses only registered occupancy, so a sample written this edge is
  // never visible to the reader until the next one.
  always_comb begin
    pop     = (level_q != 5'd0) &&
              ((state_q == IDLE) || ((state_q == N0) && bus.OutRdy));
    wr      = bus.Vld && ((level_q != FULL) || pop);
    wptr_d  = wr  ? wptr_q + ONE : wptr_q;
    rptr_d  = pop ? rptr_q + ONE : rptr_q;
    level_d = level_q;
    case ({wr, pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
    ovf_d   = ovf_q | (bus.Vld & ~wr);
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sample storage; contents are defined by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wptr_q] <= bus.Din;
  end

  // Serializer FSM with registered OutVld/Sof/Dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      outvld_q <= 1'b0;
      sof_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          hold_q   <= head;
          state_q  <= N2;
          outvld_q <= 1'b1;
          sof_q    <= 1'b1;
          dout_q   <= head[11:8];
        end
        N2: if (bus.OutRdy) begin
          state_q <= N1;
          sof_q   <= 1'b0;
          dout_q  <= hold_q[7:4];
        end
        N1: if (bus.OutRdy) begin
          state_q <= N0;
          dout_q  <= hold_q[3:0];
        end
        N0: if (bus.OutRdy) begin
          if (pop) begin
            // Back-to-back: next sample's MSB nibble follows with no bubble.
            hold_q  <= head;
            state_q <= N2;
            sof_q   <= 1'b1;
            dout_q  <= head[11:8];
          end else begin
            state_q  <= IDLE;
            outvld_q <= 1'b0;
            sof_q    <= 1'b0;
            dout_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.OutVld = outvld_q;
  assign bus.Sof    = sof_q;
  assign bus.Dout   = dout_q;
  assign bus.Level  = level_q;
  assign bus.Ovf    = ovf_q;
endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer (DEPTH=8).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_sample_serializer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [11:0] exp_q [$];
  logic [11:0] s;

  sample_serializer_if bus();

  sample_serializer #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sval(input int i);
    return {4'(i), 4'(15 - i), 4'(i + 3)};
  endfunction

  // Consume n samples from exp_q with OutRdy held high, checking every nibble.
  task automatic drain(input int n);
    logic [11:0] v;
    bus.OutRdy = 1'b1;
    for (int j = 0; j < n; j++) begin
      v = exp_q.pop_front();
      chk("drain_vld2", 32'(bus.OutVld), 32'd1);
      chk("drain_n2",   32'(bus.Dout), 32'(v[11:8]));
      chk("drain_sof2", 32'(bus.Sof),  32'd1);
      tick();
      chk("drain_n1",   32'(bus.Dout), 32'(v[7:4]));
      chk("drain_sof1", 32'(bus.Sof),  32'd0);
      tick();
      chk("drain_n0",   32'(bus.Dout), 32'(v[3:0]));
      chk("drain_vld0", 32'(bus.OutVld), 32'd1);
      tick();
    end
  endtask

  initial begin
    // ---- reset state ----
    rst = 1'b1; bus.Vld = 1'b0; bus.Din = '0; bus.OutRdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_outvld", 32'(bus.OutVld), 32'd0);
    chk("rst_sof",    32'(bus.Sof),    32'd0);
    chk("rst_dout",   32'(bus.Dout),   32'd0);
    chk("rst_level",  32'(bus.Level),  32'd0);
    chk("rst_ovf",    32'(bus.Ovf),    32'd0);

    // ---- single sample A5C ----
    bus.OutRdy = 1'b1;
    bus.Vld = 1'b1; bus.Din = 12'hA5C;
    tick();
    bus.Vld = 1'b0;
    chk("single_level1", 32'(bus.Level),  32'd1);
    chk("single_novld",  32'(bus.OutVld), 32'd0);
    tick();
    chk("single_vA",   32'(bus.OutVld), 32'd1);
    chk("single_A",    32'(bus.Dout),   32'hA);
    chk("single_sofA", 32'(bus.Sof),    32'd1);
    chk("single_lvl0", 32'(bus.Level),  32'd0);
    tick();
    chk("single_5",    32'(bus.Dout),   32'h5);
    chk("single_sof5", 32'(bus.Sof),    32'd0);
    tick();
    chk("single_C",    32'(bus.Dout),   32'hC);
    tick();
    chk("single_idle",  32'(bus.OutVld), 32'd0);
    chk("single_dout0", 32'(bus.Dout),   32'd0);
    chk("single_lvlE",  32'(bus.Level),  32'd0);

    // ---- back-to-back 123/456/789, 3 cycles apart ----
    bus.Vld = 1'b1; bus.Din = 12'h123;
    tick();
    bus.Vld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("b2b_vld", 32'(bus.OutVld), 32'd1);
      chk("b2b_nib", 32'(bus.Dout),   32'(i + 1));
      chk("b2b_sof", 32'(bus.Sof),    (i % 3 == 0) ? 32'd1 : 32'd0);
      bus.Vld = 1'b0;
      if (i == 1) begin bus.Vld = 1'b1; bus.Din = 12'h456; end
      if (i == 4) begin bus.Vld = 1'b1; bus.Din = 12'h789; end
    end
    tick();
    chk("b2b_idle", 32'(bus.OutVld), 32'd0);

    // ---- backpressure during N1 of FED ----
    bus.Vld = 1'b1; bus.Din = 12'hFED;
    tick();
    bus.Vld = 1'b0;
    tick();
    chk("bp_F", 32'(bus.Dout), 32'hF);
    tick();
    chk("bp_E", 32'(bus.Dout), 32'hE);
    bus.OutRdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_E",   32'(bus.Dout),   32'hE);
      chk("bp_hold_vld", 32'(bus.OutVld), 32'd1);
      chk("bp_hold_sof", 32'(bus.Sof),    32'd0);
    end
    bus.OutRdy = 1'b1;
    tick();
    chk("bp_D", 32'(bus.Dout), 32'hD);
    tick();
    chk("bp_idle", 32'(bus.OutVld), 32'd0);

    // ---- overflow: DEPTH+2 pulses with OutRdy low ----
    bus.OutRdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.Vld = 1'b1; bus.Din = sval(i);
      tick();
      if (i == 8) begin
        chk("ovf_pre_level", 32'(bus.Level), 32'd8);
        chk("ovf_pre_flag",  32'(bus.Ovf),   32'd0);
      end
    end
    bus.Vld = 1'b0;
    s = sval(0);
    chk("ovf_level", 32'(bus.Level), 32'd8);
    chk("ovf_flag",  32'(bus.Ovf),   32'd1);
    chk("ovf_hold",  32'(bus.Dout),  32'(s[11:8]));
    for (int i = 0; i < 9; i++) exp_q.push_back(sval(i));
    drain(9);
    chk("ovf_after_idle",   32'(bus.OutVld), 32'd0);
    chk("ovf_after_sticky", 32'(bus.Ovf),    32'd1);
    chk("ovf_after_level",  32'(bus.Level),  32'd0);

    // ---- full with simultaneous pop ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ovf", 32'(bus.Ovf), 32'd0);
    bus.OutRdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.Vld = 1'b1; bus.Din = sval(i);
      tick();
    end
    bus.Vld = 1'b0;
    chk("full_level", 32'(bus.Level), 32'd8);
    bus.OutRdy = 1'b1;
    tick(); tick();
    s = sval(0);
    chk("full_n0",     32'(bus.Dout),  32'(s[3:0]));
    chk("full_level2", 32'(bus.Level), 32'd8);
    bus.Vld = 1'b1; bus.Din = 12'hABC;
    tick();
    bus.Vld = 1'b0;
    s = sval(1);
    chk("fullpop_level", 32'(bus.Level), 32'd8);
    chk("fullpop_ovf",   32'(bus.Ovf),   32'd0);
    chk("fullpop_sof",   32'(bus.Sof),   32'd1);
    chk("fullpop_nib",   32'(bus.Dout),  32'(s[11:8]));
    for (int i = 1; i < 9; i++) exp_q.push_back(sval(i));
    exp_q.push_back(12'hABC);
    drain(9);
    chk("fullpop_idle",  32'(bus.OutVld), 32'd0);
    chk("fullpop_empty", 32'(bus.Level),  32'd0);

    // ---- mid-sample reset ----
    bus.OutRdy = 1'b1;
    bus.Vld = 1'b1; bus.Din = 12'h321;
    tick();
    bus.Din = 12'h654;
    tick();
    bus.Vld = 1'b0;
    chk("mid_n2",  32'(bus.Dout),  32'h3);
    chk("mid_lvl", 32'(bus.Level), 32'd1);
    tick();
    chk("mid_n1", 32'(bus.Dout), 32'h2);
    rst = 1'b1; bus.Vld = 1'b1; bus.Din = 12'h777;
    tick();
    rst = 1'b0; bus.Vld = 1'b0;
    chk("mid_rst_vld",  32'(bus.OutVld), 32'd0);
    chk("mid_rst_lvl",  32'(bus.Level),  32'd0);
    chk("mid_rst_ovf",  32'(bus.Ovf),    32'd0);
    chk("mid_rst_dout", 32'(bus.Dout),   32'd0);
    chk("mid_rst_sof",  32'(bus.Sof),    32'd0);
    tick(); tick();
    chk("mid_quiet_vld", 32'(bus.OutVld), 32'd0);
    chk("mid_quiet_lvl", 32'(bus.Level),  32'd0);
    bus.Vld = 1'b1; bus.Din = 12'h0F0;
    tick();
    bus.Vld = 1'b0;
    tick();
    chk("new_0a",  32'(bus.Dout),   32'h0);
    chk("new_vld", 32'(bus.OutVld), 32'd1);
    chk("new_sof", 32'(bus.Sof),    32'd1);
    tick();
    chk("new_F", 32'(bus.Dout), 32'hF);
    tick();
    chk("new_0b",   32'(bus.Dout),   32'h0);
    chk("new_vld0", 32'(bus.OutVld), 32'd1);
    tick();
    chk("new_idle", 32'(bus.OutVld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
